// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: time-multiplexes three captured BCD digits onto a 3-digit
// common-anode 7-segment display with guard clocks, leading-zero blanking,
// invalid-digit dash and a time-set blink.
module bcd_seg_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_time,
  input  logic [3:0] hun,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  output logic [7:0] seg,
  output logic [2:0] dig
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [2:0] DIG_OFF  = 3'b111;

  typedef enum logic [1:0] {
    S_ONE = 2'd0,
    S_TEN = 2'd1,
    S_HUN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            phase_q, phase_d;
  logic            slot_blank_q, slot_blank_d;
  logic            load_pend_q, load_pend_d;
  logic [3:0]      hun_q, hun_d;
  logic [3:0]      ten_q, ten_d;
  logic [3:0]      one_q, one_d;
  logic [7:0]      seg_q, seg_d;
  logic [2:0]      dig_q, dig_d;

  logic            tick;
  logic            frame_end;
  logic [3:0]      cur_val;
  logic            zero_blank;

  // Active-low 7-segment pattern with dp off; anything above 9 shows a dash.
  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  // Next-state, capture, blink and output decode computed from next values.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    frame_cnt_d  = frame_cnt_q;
    phase_d      = phase_q;
    slot_blank_d = slot_blank_q;
    load_pend_d  = 1'b0;
    hun_d        = hun_q;
    ten_d        = ten_q;
    one_d        = one_q;
    seg_d        = SEG_OFF;
    dig_d        = DIG_OFF;
    cur_val      = 4'd0;
    zero_blank   = 1'b0;

    tick      = (presc_q == PW'(SCAN_DIV - 1));
    frame_end = tick && (state_q == S_HUN);

    presc_d = tick ? '0 : presc_q + PW'(1);

    if (tick) begin
      case (state_q)
        S_ONE:   state_d = S_TEN;
        S_TEN:   state_d = S_HUN;
        default: state_d = S_ONE;
      endcase
    end

    // Shadow capture on the first edge after reset and on every frame wrap.
    if (load_pend_q || frame_end) begin
      hun_d = hun;
      ten_d = ten;
      one_d = one;
    end

    if (!en_time) begin
      frame_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (frame_end) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    // Blink blanking is decided once per slot so en_time changes act at slot boundaries.
    if (presc_d == PW'(1)) begin
      slot_blank_d = en_time && !phase_d;
    end

    case (state_d)
      S_ONE: begin
        cur_val    = one_d;
        zero_blank = 1'b0;
      end
      S_TEN: begin
        cur_val    = ten_d;
        zero_blank = (hun_d == 4'd0) && (ten_d == 4'd0);
      end
      default: begin
        cur_val    = hun_d;
        zero_blank = (hun_d == 4'd0);
      end
    endcase

    if ((presc_d != '0) && !slot_blank_d && !zero_blank) begin
      seg_d = seg7(cur_val);
      case (state_d)
        S_ONE:   dig_d = 3'b110;
        S_TEN:   dig_d = 3'b101;
        default: dig_d = 3'b011;
      endcase
    end
  end

  // State and output registers; reset puts the display dark at the ones guard clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_ONE;
      presc_q      <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b1;
      slot_blank_q <= 1'b0;
      load_pend_q  <= 1'b1;
      hun_q        <= 4'd0;
      ten_q        <= 4'd0;
      one_q        <= 4'd0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      slot_blank_q <= slot_blank_d;
      load_pend_q  <= load_pend_d;
      hun_q        <= hun_d;
      ten_q        <= ten_d;
      one_q        <= one_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Testbench for bcd_seg_scan: behavioural display model plus literal checkpoints.
module tb_bcd_seg_scan;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 3 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_time = 1'b0;
  logic [3:0] hun = 4'd0, ten = 4'd0, one = 4'd0;
  logic [7:0] seg;
  logic [2:0] dig;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: k = clock edges since reset release.
  int         k;
  logic [3:0] ch, ct, co;
  int         cnt;
  bit         ph;
  bit         sblank;
  logic [7:0] exp_seg;
  logic [2:0] exp_dig;
  logic [7:0] tbl [16];

  bcd_seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .en_time(en_time),
    .hun(hun), .ten(ten), .one(one),
    .seg(seg), .dig(dig)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    k = 0; ch = 0; ct = 0; co = 0; cnt = 0; ph = 1; sblank = 0;
    exp_seg = 8'hFF; exp_dig = 3'b111;
  endtask

  // Advance the model by one clock edge using the inputs seen on that edge.
  task automatic model_edge();
    int p, s;
    logic [3:0] v;
    bit blank;
    if (!rst) begin
      model_reset();
      return;
    end
    k++;
    p = k % SD;
    s = (k / SD) % 3;
    if (k == 1 || (k % FR) == 0) begin
      ch = hun; ct = ten; co = one;
    end
    if (!en_time) begin
      cnt = 0; ph = 1;
    end else if ((k % FR) == 0) begin
      cnt++;
      if (cnt == BF) begin
        cnt = 0; ph = !ph;
      end
    end
    if (p == 1) sblank = en_time && !ph;
    v = (s == 0) ? co : (s == 1) ? ct : ch;
    blank = (p == 0) || sblank ||
            (s == 2 && ch == 0) || (s == 1 && ch == 0 && ct == 0);
    if (blank) begin
      exp_seg = 8'hFF; exp_dig = 3'b111;
    end else begin
      exp_seg = tbl[v];
      exp_dig = (s == 0) ? 3'b110 : (s == 1) ? 3'b101 : 3'b011;
    end
  endtask

  task automatic check(input string name);
    n_cmp++;
    if (seg !== exp_seg || dig !== exp_dig) begin
      n_bad++;
      $display("FAIL %s k=%0d: got seg=%h dig=%b, expected seg=%h dig=%b",
               name, k, seg, dig, exp_seg, exp_dig);
    end
  endtask

  // Hand-computed expectation: pins both the DUT and the model.
  task automatic check_lit(input string name, input logic [7:0] s, input logic [2:0] d);
    n_cmp++;
    if (seg !== s || dig !== d) begin
      n_bad++;
      $display("FAIL %s dut: got seg=%h dig=%b, expected seg=%h dig=%b", name, seg, dig, s, d);
    end
    n_cmp++;
    if (exp_seg !== s || exp_dig !== d) begin
      n_bad++;
      $display("FAIL %s model: got seg=%h dig=%b, expected seg=%h dig=%b", name, exp_seg, exp_dig, s, d);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(name);
  endtask

  // Step at least once, then until the frame position k%FR reaches target.
  task automatic goto(input int target);
    int guard = 0;
    do begin
      step("scan");
      guard++;
    end while ((k % FR) != target && guard < 3 * FR);
    if ((k % FR) != target) begin
      n_cmp++; n_bad++;
      $display("FAIL goto: got pos=%0d, expected pos=%0d", k % FR, target);
    end
  endtask

  task automatic set_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    hun = h; ten = t; one = o;
  endtask

  initial begin
    tbl[0] = 8'hC0; tbl[1] = 8'hF9; tbl[2] = 8'hA4; tbl[3] = 8'hB0;
    tbl[4] = 8'h99; tbl[5] = 8'h92; tbl[6] = 8'h82; tbl[7] = 8'hF8;
    tbl[8] = 8'h80; tbl[9] = 8'h90;
    for (int i = 10; i < 16; i++) tbl[i] = 8'hBF;
    model_reset();

    // Reset held with random inputs.
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_digits(4'($urandom), 4'($urandom), 4'($urandom));
      en_time = 1'($urandom);
      step("reset_hold");
    end
    en_time = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3);
    rst = 1'b1;
    #1 check_lit("guard_after_reset", 8'hFF, 3'b111);
    step("first"); check_lit("ones_1", 8'hB0, 3'b110);
    step("ones");  check_lit("ones_2", 8'hB0, 3'b110);
    step("ones");  check_lit("ones_3", 8'hB0, 3'b110);
    step("guard"); check_lit("ten_guard", 8'hFF, 3'b111);
    goto(5);       check_lit("tens_123", 8'hA4, 3'b101);
    goto(9);       check_lit("hun_123", 8'hF9, 3'b011);
    goto(0);       check_lit("frame_guard", 8'hFF, 3'b111);

    // Leading-zero blanking.
    set_digits(4'd0, 4'd0, 4'd7);
    goto(0); goto(1); check_lit("b007_ones", 8'hF8, 3'b110);
    goto(5);          check_lit("b007_tens", 8'hFF, 3'b111);
    goto(9);          check_lit("b007_hun", 8'hFF, 3'b111);
    set_digits(4'd0, 4'd5, 4'd0);
    goto(0); goto(1); check_lit("b050_ones", 8'hC0, 3'b110);
    goto(5);          check_lit("b050_tens", 8'h92, 3'b101);
    goto(9);          check_lit("b050_hun", 8'hFF, 3'b111);
    set_digits(4'd0, 4'd0, 4'd0);
    goto(0); goto(1); check_lit("b000_ones", 8'hC0, 3'b110);
    goto(5);          check_lit("b000_tens", 8'hFF, 3'b111);

    // Invalid digits show a dash and are never blanked.
    set_digits(4'd0, 4'hA, 4'hC);
    goto(0); goto(1); check_lit("inv_ones", 8'hBF, 3'b110);
    goto(5);          check_lit("inv_tens", 8'hBF, 3'b101);
    goto(9);          check_lit("inv_hun", 8'hFF, 3'b111);

    // Frame coherency: mid-frame input change is deferred.
    set_digits(4'd1, 4'd2, 4'd3);
    goto(0); goto(6); check_lit("coh_tens_old", 8'hA4, 3'b101);
    set_digits(4'd4, 4'd5, 4'd6);
    goto(7);          check_lit("coh_tens_held", 8'hA4, 3'b101);
    goto(9);          check_lit("coh_hun_old", 8'hF9, 3'b011);
    goto(1);          check_lit("coh_ones_new", 8'h82, 3'b110);
    goto(5);          check_lit("coh_tens_new", 8'h92, 3'b101);
    goto(9);          check_lit("coh_hun_new", 8'h99, 3'b011);

    // Blink: two frames on, two frames off.
    goto(0);
    en_time = 1'b1;
    goto(1); check_lit("blink_on_f1", 8'h82, 3'b110);
    goto(1); check_lit("blink_on_f2", 8'h82, 3'b110);
    goto(1); check_lit("blink_off_f3", 8'hFF, 3'b111);
    goto(9); check_lit("blink_off_f3h", 8'hFF, 3'b111);
    goto(1); check_lit("blink_off_f4", 8'hFF, 3'b111);
    goto(1); check_lit("blink_on_f5", 8'h82, 3'b110);
    goto(1); goto(1); check_lit("blink_off_f7", 8'hFF, 3'b111);
    goto(6);
    en_time = 1'b0;
    goto(7); check_lit("drop_same_slot", 8'hFF, 3'b111);
    goto(9); check_lit("drop_next_slot", 8'h99, 3'b011);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_digits(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) hun = 4'd0;
        if ($urandom_range(0, 1) == 0) ten = 4'd0;
      end
      if ($urandom_range(0, 40) == 0) en_time = ~en_time;
      step("random");
    end

    // Mid-slot asynchronous reset.
    en_time = 1'b0;
    set_digits(4'd3, 4'd2, 4'd1);
    goto(0); goto(6);
    #2 rst = 1'b0;
    model_reset();
    #1 check_lit("async_reset", 8'hFF, 3'b111);
    step("reset_low");
    step("reset_low");
    rst = 1'b1;
    #1 check_lit("restart_guard", 8'hFF, 3'b111);
    step("restart"); check_lit("restart_ones", 8'hF9, 3'b110);
    for (int i = 0; i < 3 * FR; i++) step("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the binary-to-BCD stage in the watch datapath.
- Takes registered hun/ten/one BCD digits and time-multiplexes them onto a 3-digit common-anode 7-segment display.
- Provides leading-zero blanking, invalid-digit indication and a blink while time-set mode (en_time) is active.
- Captures inputs once per frame so every frame displays one coherent value.

Parameters:
- SCAN_DIV, 1000: clocks per digit slot, including 1 guard clock. Minimum 2.
- BLINK_FRAMES, 100: frames per blink half-period. Minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- en_time  input  1  time-set mode; 1 = blink display
- hun  input  4  BCD hundreds digit
- ten  input  4  BCD tens digit
- one  input  4  BCD ones digit
- seg  output  8  active-low segments, seg[7]=dp, seg[6:0]=g..a
- dig  output  3  active-low digit enables, dig[0]=ones, dig[1]=tens, dig[2]=hundreds

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low. All state resets on the falling edge of rst, with no clock required.
- Reset values: seg=8'hFF, dig=3'b111, state=S_ONE, prescaler=0, frame/blink counters=0, blink phase=on, shadow digits=0.
- Outputs: seg and dig are registers with no combinational path from the inputs.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. The slot-advance tick occurs at SCAN_DIV-1.
- Digit FSM: S_ONE -> S_TEN -> S_HUN -> S_ONE, advancing on each tick. Each state lasts exactly SCAN_DIV clocks; one frame = 3*SCAN_DIV clocks.
- Guard clock: in the first clock of every slot (prescaler=0), dig=111 and seg=FF (anti-ghosting). For the remaining SCAN_DIV-1 clocks, the slot's digit is driven.
- Frame capture: the clock edge that enters S_ONE (including the first edge after reset release) loads shadow regs from hun/ten/one. Input changes mid-frame are invisible until the next frame.
- Encoding (active-low, dp always off):
  - Digits 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Value >9: BF (dash).
- Blanking: a blanked slot drives dig=111, seg=FF for the whole slot.
  - Hundreds blanked when shadow hun==0.
  - Tens blanked when shadow hun==0 and shadow ten==0.
  - Ones never blanked.
  - An invalid digit (>9) is never blanked.
- Blink:
  - Frame counter increments at each frame end (tick while in S_HUN), counting 0..BLINK_FRAMES-1.
  - On wrap, blink phase toggles.
  - While en_time=1 and phase=off, every slot drives dig=111, seg=FF.
  - While en_time=0: frame counter held at 0, phase forced on.
  - en_time rising: the first displayed frame is on, and blinking starts from that point.
  - en_time falling mid-frame: display resumes from the next slot.
- Reset mid-frame: outputs go to reset values immediately; scanning restarts at S_ONE guard after release.
- Simultaneous events: frame-end tick and en_time change on the same edge → the en_time value sampled on that edge governs.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
1. Reset: hold rst=0 over 10 clocks with random inputs -> seg=FF, dig=111 throughout. After release -> first clock guard (111/FF), then dig=110 for 3 clocks.
2. hun=1, ten=2, one=3 -> per frame:
   - S_ONE: dig=110, seg=B0.
   - S_TEN: dig=101, seg=A4.
   - S_HUN: dig=011, seg=F9.
   - Each slot preceded by a 1-clock 111/FF guard; period 12 clocks.
3. Blanking:
   - 0,0,7 -> ones slot seg=F8; tens and hundreds slots 111/FF.
   - 0,5,0 -> ones C0, tens 92, hundreds blank.
   - 0,0,0 -> ones C0 only.
4. Invalid digit: one=4'hC, ten=4'hA, hun=0 -> ones BF and tens BF (tens not blanked).
5. Coherency: change 1,2,3 to 4,5,6 during S_TEN -> rest of frame shows 2 and 1; the next frame shows 6, 5, 4.
6. Blink and mid-frame reset:
   - en_time=1 -> 2 frames on, 2 frames all 111/FF, repeating.
   - Drop en_time during an off frame -> the next slot displays.
   - Pulse rst low mid-slot -> immediate FF/111, then restart at S_ONE guard.
